// File: rtl/ps2_msg_tx_ctrl.sv
// ps2_msg_tx_ctrl: builds a fixed-length keyboard message from ASCII
// keystrokes, then hands it to the GPIO link and waits for completion.
//
// Handshake with the link: data_ready is high only in SEND. While it is high,
// message_out and msg_len do not change. The link raises link_done (a level)
// when the transfer is complete. The controller then clears the buffer and
// waits in RELEASE until link_done falls, so that a done held high cannot
// start a second transfer.
module ps2_msg_tx_ctrl #(
  parameter int          MAX_CHARS      = 16,
  parameter logic [7:0]  DEL_CODE       = 8'd127,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             char_valid,
  input  logic [7:0]                       char_ascii,
  input  logic                             send_req,
  input  logic                             link_done,
  output logic                             data_ready,
  output logic [8*MAX_CHARS-1:0]           message_out,
  output logic [$clog2(MAX_CHARS+1)-1:0]   msg_len,
  output logic [1:0]                       fsm_state,
  output logic                             char_drop,
  output logic                             send_ok,
  output logic                             send_timeout
);

  localparam int LW = $clog2(MAX_CHARS + 1);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [LW-1:0] FULL = LW'(MAX_CHARS);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'b00,
    SEND    = 2'b01,
    RELEASE = 2'b10,
    UNUSED  = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      buf_q [MAX_CHARS];
  logic [7:0]      buf_d [MAX_CHARS];
  logic [LW-1:0]   len_q, len_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            drop_d, ok_d, to_d, ready_d;
  logic [LW-1:0]   len_m1;

  assign len_m1 = len_q - LW'(1);

  // Next-state, buffer edits and pulse outputs for the coming cycle.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    drop_d  = 1'b0;
    ok_d    = 1'b0;
    to_d    = 1'b0;
    case (state_q)
      COLLECT: begin
        if (char_valid) begin
          if (char_ascii == DEL_CODE) begin
            // DEL on an empty buffer does nothing and is not a drop.
            if (len_q != '0) begin
              for (int i = 0; i < MAX_CHARS; i++)
                if (LW'(i) == len_m1) buf_d[i] = 8'h00;
              len_d = len_m1;
            end
          end else if (len_q != FULL) begin
            for (int i = 0; i < MAX_CHARS; i++)
              if (LW'(i) == len_q) buf_d[i] = char_ascii;
            len_d = len_q + LW'(1);
          end else begin
            drop_d = 1'b1;
          end
        end
        // The same-cycle char counts, so test the updated length.
        if (send_req && (len_d != '0)) begin
          state_d = SEND;
          cnt_d   = '0;
        end
      end
      SEND: begin
        drop_d = char_valid;
        if (link_done) begin
          for (int i = 0; i < MAX_CHARS; i++) buf_d[i] = 8'h00;
          len_d   = '0;
          ok_d    = 1'b1;
          state_d = RELEASE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == LAST)) begin
          to_d    = 1'b1;
          state_d = COLLECT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RELEASE: begin
        drop_d = char_valid;
        if (!link_done) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
    ready_d = (state_d == SEND);
  end

  // State, buffer and registered outputs; reset clears everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= COLLECT;
      buf_q        <= '{default: 8'h00};
      len_q        <= '0;
      cnt_q        <= '0;
      data_ready   <= 1'b0;
      char_drop    <= 1'b0;
      send_ok      <= 1'b0;
      send_timeout <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      data_ready   <= ready_d;
      char_drop    <= drop_d;
      send_ok      <= ok_d;
      send_timeout <= to_d;
    end
  end

  // Slot 0 (first char) sits in the most significant byte.
  for (genvar g = 0; g < MAX_CHARS; g++) begin : g_pack
    assign message_out[8*(MAX_CHARS-g)-1 -: 8] = buf_q[g];
  end

  assign msg_len   = len_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_ps2_msg_tx_ctrl.sv
// Bench for ps2_msg_tx_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a queue-based model of the message buffer.
module tb_ps2_msg_tx_ctrl;

  localparam int TMO = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         char_valid;
  logic [7:0]   char_ascii;
  logic         send_req;
  logic         link_done;
  logic         data_ready;
  logic [127:0] message_out;
  logic [4:0]   msg_len;
  logic [1:0]   fsm_state;
  logic         char_drop;
  logic         send_ok;
  logic         send_timeout;

  int n_pass  = 0;
  int n_total = 0;

  // model: stored chars, mode (0 collect, 1 send, 2 release), cycles spent in send
  logic [7:0] m_q[$];
  int         m_mode = 0;
  int         m_cnt  = 0;
  logic       e_dr, e_drop, e_ok, e_to;

  // tallies of observed pulses for scenario-level checks
  int drop_seen, ok_seen, to_seen, dr_seen;

  ps2_msg_tx_ctrl #(.MAX_CHARS(16), .DEL_CODE(8'd127), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .char_valid(char_valid), .char_ascii(char_ascii),
    .send_req(send_req), .link_done(link_done), .data_ready(data_ready),
    .message_out(message_out), .msg_len(msg_len), .fsm_state(fsm_state),
    .char_drop(char_drop), .send_ok(send_ok), .send_timeout(send_timeout)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [127:0] model_msg();
    logic [127:0] m = '0;
    for (int i = 0; i < m_q.size(); i++) m[8*(16-i)-1 -: 8] = m_q[i];
    return m;
  endfunction

  // One clock of the specification's rules applied to the model.
  task automatic model_step(input logic cv, input logic [7:0] ch, input logic sr,
                            input logic ld, input logic rst);
    e_drop = 0; e_ok = 0; e_to = 0;
    if (rst) begin
      m_q.delete(); m_mode = 0; m_cnt = 0;
    end else if (m_mode == 0) begin
      if (cv) begin
        if (ch == 8'd127) begin
          if (m_q.size() > 0) void'(m_q.pop_back());
        end else if (m_q.size() < 16) m_q.push_back(ch);
        else e_drop = 1;
      end
      if (sr && m_q.size() > 0) begin m_mode = 1; m_cnt = 0; end
    end else if (m_mode == 1) begin
      e_drop = cv;
      if (ld) begin m_q.delete(); e_ok = 1; m_mode = 2; end
      else if (m_cnt == TMO - 1) begin e_to = 1; m_mode = 0; end
      else m_cnt++;
    end else begin
      e_drop = cv;
      if (!ld) m_mode = 0;
    end
    e_dr = (m_mode == 1);
  endtask

  task automatic step(input logic cv, input logic [7:0] ch, input logic sr,
                      input logic ld, input logic rst);
    char_valid = cv; char_ascii = ch; send_req = sr; link_done = ld; reset = rst;
    @(posedge clock);
    model_step(cv, ch, sr, ld, rst);
    #1;
    check("data_ready",   data_ready,   e_dr);
    check("message_out",  message_out,  model_msg());
    check("msg_len",      msg_len,      m_q.size());
    check("fsm_state",    fsm_state,    m_mode);
    check("char_drop",    char_drop,    e_drop);
    check("send_ok",      send_ok,      e_ok);
    check("send_timeout", send_timeout, e_to);
    drop_seen += char_drop; ok_seen += send_ok; to_seen += send_timeout; dr_seen += data_ready;
  endtask

  task automatic key(input logic [7:0] ch);
    step(1, ch, 0, 0, 0);
  endtask

  task automatic idle(input logic ld);
    step(0, 8'h00, 0, ld, 0);
  endtask

  initial begin
    char_valid = 0; char_ascii = 0; send_req = 0; link_done = 0; reset = 1;

    // reset state
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    check("rst_all_zero", {data_ready, message_out, msg_len, fsm_state, char_drop, send_ok, send_timeout}, '0);

    // 'h','i' then send
    key(8'h68); key(8'h69);
    step(0, 8'h00, 1, 0, 0);
    check("hi_ready", data_ready, 1'b1);
    check("hi_msg_hi", message_out[127:112], 16'h6869);
    check("hi_msg_rest", message_out[111:0], '0);
    check("hi_len", msg_len, 5'd2);

    // link_done held 5 cycles, then released
    ok_seen = 0;
    for (int i = 0; i < 5; i++) idle(1);
    check("done_ok_once", ok_seen, 1);
    check("done_release", fsm_state, 2'b10);
    check("done_len", msg_len, 5'd0);
    idle(0);
    check("done_collect", fsm_state, 2'b00);

    // 17 'a' : one drop on the last
    drop_seen = 0;
    for (int i = 0; i < 17; i++) key(8'h61);
    check("full_len", msg_len, 5'd16);
    check("full_msg", message_out, {16{8'h61}});
    check("full_drop_once", drop_seen, 1);
    step(0, 8'h00, 1, 0, 0);
    idle(1); idle(0);

    // 'a','b', DEL x3
    drop_seen = 0;
    key(8'h61); check("del_len1", msg_len, 5'd1);
    key(8'h62); check("del_len2", msg_len, 5'd2);
    key(8'd127); check("del_len3", msg_len, 5'd1);
    key(8'd127); check("del_len4", msg_len, 5'd0);
    key(8'd127); check("del_len5", msg_len, 5'd0);
    check("del_msg", message_out, '0);
    check("del_no_drop", drop_seen, 0);

    // timeout: data_ready high for exactly TMO cycles, buffer preserved
    key(8'h78);
    dr_seen = 0; to_seen = 0;
    step(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 10; i++) idle(0);
    check("tmo_dr_cycles", dr_seen, TMO);
    check("tmo_pulse_once", to_seen, 1);
    check("tmo_len_kept", msg_len, 5'd1);
    check("tmo_msg_kept", message_out[127:120], 8'h78);

    // send_req on an empty buffer stays in COLLECT
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 1, 0, 0);
    check("empty_send_state", fsm_state, 2'b00);

    // same-cycle 'z' and send_req, then reset in SEND
    step(1, 8'h7A, 1, 0, 0);
    check("z_state", fsm_state, 2'b01);
    check("z_len", msg_len, 5'd1);
    check("z_msg", message_out[127:120], 8'h7A);
    step(0, 8'h00, 0, 0, 1);
    check("rst_in_send", {data_ready, message_out, msg_len, fsm_state, char_drop, send_ok, send_timeout}, '0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic       cv, sr, ld, rst;
      logic [7:0] ch;
      cv  = ($urandom_range(0, 99) < 45);
      ch  = ($urandom_range(0, 4) == 0) ? 8'd127 : 8'(8'h20 + $urandom_range(0, 94));
      sr  = ($urandom_range(0, 99) < 12);
      ld  = (link_done && $urandom_range(0, 99) < 70) || ($urandom_range(0, 99) < 12);
      rst = ($urandom_range(0, 199) == 0);
      step(cv, ch, sr, ld, rst);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
